updown_bcd_counter: RTL and testbench

UPDOWN_BCD_COUNTER -- requirements
Module: updown_bcd_counter

---
 rtl/updown_bcd_counter.sv | 110 +++++++++++
 tb/tb_updown_bcd_counter.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/updown_bcd_counter.sv
// Two-digit BCD up/down counter driven by up/down buttons and a count-enable tick.
// Define UPDOWN_SATURATE_EN to hold at the limits and drop to PAUSE instead of wrapping.
module updown_bcd_counter #(
  parameter logic [3:0] MAX_TENS = 4'd5,
  parameter logic [3:0] MAX_ONES = 4'd9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_up_pulse,
  input  logic       in_down_pulse,
  input  logic       cnt_tick,
  output logic [3:0] digit_tens,
  output logic [3:0] digit_ones,
  output logic [1:0] mode,
  output logic       limit_pulse
);

  typedef enum logic [1:0] {
    PAUSE      = 2'b00,
    COUNT_UP   = 2'b01,
    COUNT_DOWN = 2'b10,
    ILLEGAL    = 2'b11
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] tens_q, ones_q, tens_d, ones_d;
  logic       limit_q, limit_d;
  logic       at_limit, above_limit, at_zero;

  // Digits never exceed 9, so the packed BCD byte orders the same way as the count.
  assign at_limit    = ({tens_q, ones_q} == {MAX_TENS, MAX_ONES});
  assign above_limit = ({tens_q, ones_q} >  {MAX_TENS, MAX_ONES});
  assign at_zero     = ({tens_q, ones_q} == 8'h00);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= PAUSE;
      tens_q  <= 4'd0;
      ones_q  <= 4'd0;
      limit_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tens_q  <= tens_d;
      ones_q  <= ones_d;
      limit_q <= limit_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tens_d  = tens_q;
    ones_d  = ones_q;
    limit_d = 1'b0;

    if (in_up_pulse && in_down_pulse) begin
      state_d = PAUSE;
    end else if (in_up_pulse) begin
      state_d = (state_q == COUNT_UP) ? PAUSE : COUNT_UP;
    end else if (in_down_pulse) begin
      state_d = (state_q == COUNT_DOWN) ? PAUSE : COUNT_DOWN;
    end
    if (state_q == ILLEGAL) begin
      state_d = PAUSE;
    end

    // The tick acts on the state held before this edge's button transition.
    if (cnt_tick) begin
      if (state_q == COUNT_UP) begin
        if (above_limit) begin
          tens_d = 4'd0;
          ones_d = 4'd0;
        end else if (at_limit) begin
          limit_d = 1'b1;
`ifdef UPDOWN_SATURATE_EN
          state_d = PAUSE;
`else
          tens_d = 4'd0;
          ones_d = 4'd0;
`endif
        end else if (ones_q >= 4'd9) begin
          ones_d = 4'd0;
          tens_d = tens_q + 4'd1;
        end else begin
          ones_d = ones_q + 4'd1;
        end
      end else if (state_q == COUNT_DOWN) begin
        if (at_zero) begin
          limit_d = 1'b1;
`ifdef UPDOWN_SATURATE_EN
          state_d = PAUSE;
`else
          tens_d = MAX_TENS;
          ones_d = MAX_ONES;
`endif
        end else if (ones_q == 4'd0) begin
          ones_d = 4'd9;
          tens_d = tens_q - 4'd1;
        end else begin
          ones_d = ones_q - 4'd1;
        end
      end
    end
  end

  assign digit_tens  = tens_q;
  assign digit_ones  = ones_q;
  assign mode        = state_q;
  assign limit_pulse = limit_q;

endmodule

// File: tb/tb_updown_bcd_counter.sv
// Scoreboard bench for updown_bcd_counter: directed scenarios then random buttons/ticks,
// checked against an integer-count reference model.
module tb_updown_bcd_counter;

  localparam logic [3:0] MAX_TENS = 4'd5;
  localparam logic [3:0] MAX_ONES = 4'd9;
  localparam int LIMIT = 59;

  logic       clk;
  logic       rst;
  logic       in_up_pulse;
  logic       in_down_pulse;
  logic       cnt_tick;
  logic [3:0] digit_tens;
  logic [3:0] digit_ones;
  logic [1:0] mode;
  logic       limit_pulse;

  typedef struct {
    logic [3:0] tens;
    logic [3:0] ones;
    logic [1:0] mode;
    logic       pulse;
  } exp_t;

  exp_t exp_q[$];
  int   assertions = 0;
  int   failures   = 0;
  int   model_count = 0;
  int   model_mode  = 0;
  bit   stim_done   = 0;

  updown_bcd_counter #(.MAX_TENS(MAX_TENS), .MAX_ONES(MAX_ONES)) dut (
    .clk(clk),
    .rst(rst),
    .in_up_pulse(in_up_pulse),
    .in_down_pulse(in_down_pulse),
    .cnt_tick(cnt_tick),
    .digit_tens(digit_tens),
    .digit_ones(digit_ones),
    .mode(mode),
    .limit_pulse(limit_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one cycle of inputs and pushes the response the counter must show after the next edge.
  task automatic applyStimulus(input bit r, input bit up, input bit down, input bit tick);
    int   next_mode;
    bit   pulse;
    exp_t e;
    @(negedge clk);
    rst = r;
    in_up_pulse = up;
    in_down_pulse = down;
    cnt_tick = tick;
    pulse = 1'b0;
    if (r) begin
      model_count = 0;
      model_mode  = 0;
    end else begin
      if (up && down)  next_mode = 0;
      else if (up)     next_mode = (model_mode == 1) ? 0 : 1;
      else if (down)   next_mode = (model_mode == 2) ? 0 : 2;
      else             next_mode = model_mode;
      if (tick && model_mode == 1) begin
        if (model_count == LIMIT) begin
          pulse = 1'b1;
`ifdef UPDOWN_SATURATE_EN
          next_mode = 0;
`else
          model_count = 0;
`endif
        end else begin
          model_count = model_count + 1;
        end
      end else if (tick && model_mode == 2) begin
        if (model_count == 0) begin
          pulse = 1'b1;
`ifdef UPDOWN_SATURATE_EN
          next_mode = 0;
`else
          model_count = LIMIT;
`endif
        end else begin
          model_count = model_count - 1;
        end
      end
      model_mode = next_mode;
    end
    e.tens  = 4'(model_count / 10);
    e.ones  = 4'(model_count % 10);
    e.mode  = 2'(model_mode);
    e.pulse = pulse;
    exp_q.push_back(e);
  endtask

  task automatic checkOutput(input exp_t e);
    assertions++;
    if (digit_tens !== e.tens || digit_ones !== e.ones || mode !== e.mode || limit_pulse !== e.pulse) begin
      failures++;
      $display("[TB] FAIL scoreboard t=%0t: got tens=%0d ones=%0d mode=%b pulse=%b, expected tens=%0d ones=%0d mode=%b pulse=%b",
               $time, digit_tens, digit_ones, mode, limit_pulse, e.tens, e.ones, e.mode, e.pulse);
    end
  endtask

  // Monitor: every registered output update is compared against the oldest pending expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput(e);
      end
    end
  end

  initial begin
    rst = 1'b0;
    in_up_pulse = 1'b0;
    in_down_pulse = 1'b0;
    cnt_tick = 1'b0;

    // Reset, up pulse, three ticks to 03.
    applyStimulus(1, 0, 0, 0);
    applyStimulus(0, 1, 0, 0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 1);
    // Run to the limit, across it, and back down through zero.
    for (int i = 0; i < 56; i++) applyStimulus(0, 0, 0, 1);
    applyStimulus(0, 0, 0, 1);
    applyStimulus(0, 0, 0, 1);
    applyStimulus(0, 0, 1, 0);
    applyStimulus(0, 0, 0, 1);
    applyStimulus(0, 0, 0, 1);
    // Reset then BCD carry/borrow around 09/10.
    applyStimulus(1, 0, 0, 0);
    applyStimulus(0, 1, 0, 0);
    for (int i = 0; i < 10; i++) applyStimulus(0, 0, 0, 1);
    applyStimulus(0, 0, 1, 0);
    applyStimulus(0, 0, 0, 1);
    applyStimulus(0, 1, 0, 0);
    applyStimulus(0, 0, 0, 1);
    // Simultaneous buttons pause; ticks hold; up toggles back and forth.
    applyStimulus(0, 1, 1, 0);
    applyStimulus(0, 0, 0, 1);
    applyStimulus(0, 0, 0, 1);
    applyStimulus(0, 1, 0, 0);
    applyStimulus(0, 1, 0, 0);
    applyStimulus(0, 1, 0, 0);
    // Button coincident with tick, then reset coincident with tick.
    applyStimulus(0, 0, 1, 1);
    applyStimulus(0, 0, 0, 1);
    applyStimulus(1, 1, 0, 1);
    applyStimulus(0, 0, 1, 1);
    applyStimulus(0, 0, 0, 1);

    for (int i = 0; i < 3000; i++) begin
      automatic int r = $urandom_range(0, 399);
      automatic int b = $urandom_range(0, 31);
      applyStimulus(r == 0, b == 0 || b == 2, b == 1 || b == 2, $urandom_range(0, 1) == 1);
    end
    applyStimulus(0, 0, 0, 0);

    stim_done = 1'b1;
    repeat (3) @(posedge clk);
    #3;
    assertions++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
